// File: rtl/divider32.sv
`default_nettype none
// ============================================================================
// Module   : divider32
// Purpose  : Multi-cycle 32-bit integer divider (radix-2 restoring division).
//            One trial subtraction per clock, 32 iterations, plus one FIX
//            cycle. Produces quotient and remainder for DIV/DIVU/REM/REMU.
//            Divide-by-zero returns Q=all ones, R=dividend in one cycle.
// Config   : DIVIDER32_SIGNED_EN - when defined, is_signed selects RISC-V M
//            signed semantics (magnitude conversion + FIX sign correction).
//            When undefined, all division is unsigned and is_signed is ignored.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            start        request, accepted only when busy=0
//            is_signed    signed operands (sampled with start)
//            A, B         dividend / divisor (sampled on accepted start)
//            busy         division in flight (CALC and FIX)
//            done         one-cycle result-valid pulse
//            Q, R         quotient / remainder, held until next accepted start
//            DIV_BY_ZERO  set with done when B=0, held with Q/R
// Revision : 1.0 - initial release
// ============================================================================
module divider32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        DIV_BY_ZERO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [32:0] rem;       // partial remainder; bit 32 is headroom for the shift
  logic [31:0] dvd;       // dividend shifts out the top, quotient bits enter the bottom
  logic [31:0] dvs;       // divisor magnitude
  logic [4:0]  count;

  logic        accept;
  logic        b_zero;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign b_zero = (B == 32'd0);

`ifdef DIVIDER32_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign a_neg = is_signed & A[31];
  assign b_neg = is_signed & B[31];
  assign q_fix = neg_q ? (32'd0 - dvd) : dvd;
  assign r_fix = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept && !b_zero) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign q_fix = dvd;
  assign r_fix = rem[31:0];
`endif

  assign a_mag = a_neg ? (32'd0 - A) : A;
  assign b_mag = b_neg ? (32'd0 - B) : B;

  // 33-bit trial subtraction: the borrow lands in bit 32, so trial[32]=0
  // means the shifted remainder was at least the divisor.
  assign rem_sh = {rem[31:0], dvd[31]};
  assign trial  = rem_sh - {1'b0, dvs};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = b_zero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = b_zero ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= 33'd0;
      dvd         <= 32'd0;
      dvs         <= 32'd0;
      count       <= 5'd0;
      Q           <= 32'd0;
      R           <= 32'd0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      if (accept) begin
        if (b_zero) begin
          Q           <= 32'hFFFF_FFFF;
          R           <= A;
          DIV_BY_ZERO <= 1'b1;
        end else begin
          rem         <= 33'd0;
          dvd         <= a_mag;
          dvs         <= b_mag;
          count       <= 5'd0;
          DIV_BY_ZERO <= 1'b0;
        end
      end else if (state == CALC) begin
        if (!trial[32]) begin
          rem <= trial;
          dvd <= {dvd[30:0], 1'b1};
        end else begin
          rem <= rem_sh;
          dvd <= {dvd[30:0], 1'b0};
        end
        count <= count + 5'd1;
      end else if (state == FIX) begin
        Q <= q_fix;
        R <= r_fix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider32.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider32
// Purpose  : Directed self-checking bench for divider32. Expected values are
//            hand-computed; signed expectations follow DIVIDER32_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        DIV_BY_ZERO;

  int checks;
  int errors;

  divider32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request that is sampled at the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start     = 1'b1;
    A         = a;
    B         = b;
    is_signed = s;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges after the accepting edge until done is seen.
  task automatic wait_done(input string tag, output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) break;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int elat, input int ebusy);
    int n, nb;
    issue(a, b, s);
    wait_done(tag, n, nb);
    check({tag, "_lat"},  n,  elat);
    check({tag, "_busy"}, nb, ebusy);
    check({tag, "_Q"},    Q,  eq);
    check({tag, "_R"},    R,  er);
    check({tag, "_dbz"},  {31'd0, DIV_BY_ZERO}, {31'd0, edz});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, nb, seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_Q", Q, 32'd0);
    check("rst_R", R, 32'd0);
    check("rst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33);
    // done lasts one cycle, results held afterwards
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("hold_Q", Q, 32'd14);

`ifdef DIVIDER32_SIGNED_EN
    run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 33);
    run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, 33);
    run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 33);
`else
    run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 33);
    run("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34, 33);
`endif
    run("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 33);
    run("dz_u", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
    run("dz_s", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
    run("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 33);
    run("u_small", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, 1'b0, 34, 33);

    // start while busy is ignored, then a back-to-back start in the done cycle
    issue(32'd100, 32'd7, 1'b0);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    check("ign_lat", n, 34);
    check("ign_Q", Q, 32'd14);
    check("ign_R", R, 32'd2);
    start = 1'b1;
    A     = 32'd9;
    B     = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b", n, nb);
    check("b2b_lat", n, 34);
    check("b2b_Q", Q, 32'd3);
    check("b2b_R", R, 32'd0);

    // reset during iteration 10 aborts immediately
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_Q", Q, 32'd0);
    check("arst_R", R, 32'd0);
    check("arst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("arst_no_done", seen, 0);
    run("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
